// File: rtl/packet_assembler.sv
// Packet assembler: gathers four 32-bit upstream words into a 128-bit packet,
// screens framing and type errors, and buffers good packets in a FIFO.
module packet_assembler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [31:0]                 s_data,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic                        m_valid,
    output logic [127:0]                m_data,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 pkt_count,
    output logic                        err_short,
    output logic                        err_long,
    output logic                        err_type
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [95:0]    stage_q, stage_d;
    logic [127:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [15:0]    count_q, count_d;
    logic           err_short_q, err_short_d;
    logic           err_long_q, err_long_d;
    logic           err_type_q, err_type_d;
    logic           word_xfer;
    logic           push;
    logic           pop;

    // Ready depends on registers only, so a pop in this cycle cannot open a slot.
    assign s_ready    = (state_q == DISCARD) || (idx_q != 2'd3) || (level_q < FULL_LEVEL);
    assign m_valid    = (level_q != '0);
    assign m_data     = mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign pkt_count  = count_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;
    assign err_type   = err_type_q;

    assign word_xfer = s_valid && s_ready;
    assign pop       = m_valid && m_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        stage_d     = stage_q;
        count_d     = count_q;
        push        = 1'b0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_type_d  = 1'b0;

        if (word_xfer) begin
            case (state_q)
                COLLECT: begin
                    if (idx_q != 2'd3) begin
                        if (s_last) begin
                            idx_d       = 2'd0;
                            err_short_d = 1'b1;
                        end else begin
                            case (idx_q)
                                2'd0:    stage_d[95:64] = s_data;
                                2'd1:    stage_d[63:32] = s_data;
                                default: stage_d[31:0]  = s_data;
                            endcase
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        idx_d = 2'd0;
                        if (!s_last) begin
                            err_long_d = 1'b1;
                            state_d    = DISCARD;
                        end else if (stage_q[95:94] == 2'b11) begin
                            err_type_d = 1'b1;
                        end else begin
                            push    = 1'b1;
                            count_d = count_q + 16'd1;
                        end
                    end
                end
                DISCARD: begin
                    if (s_last) begin
                        state_d = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q     <= COLLECT;
            idx_q       <= 2'd0;
            stage_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            count_q     <= 16'd0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_type_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stage_q     <= stage_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            count_q     <= count_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_type_q  <= err_type_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the storage is reset because m_data reads it directly and must be zero in reset.
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {stage_q, s_data};
        end
    end

endmodule
